div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU; sits beside the execute stage, which drives its operands and start request and stalls the pipeline until the result is ready.
- Uses a radix-2 restoring algorithm, one quotient bit per clock, with sign pre/post-correction for signed division.
- The 64-bit result {remainder, quotient} is consumed by execute as {hi, lo} for the HI/LO write-back path.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance
- opdata1_i  input  DATA_W  dividend; sampled at start acceptance
- opdata2_i  input  DATA_W  divisor; sampled at start acceptance
- start_i  input  1  division request; level, held high by execute until ready_o is seen
- annul_i  input  1  abort the current division (branch/exception flush)
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid while ready_o=1
- ready_o  output  1  result valid

Behaviour:
- Reset (rst=0, async): state=DIV_FREE, ready_o=0, result_o=0, iteration counter=0, datapath registers cleared. Reset mid-division discards all work.
- States: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END.
- DIV_FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> DIV_BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> DIV_ON; cnt=0. Latch operands as absolute values when signed_div_i=1 and the operand is negative; otherwise latch raw. Latch signed_div_i and both sign bits.
  - Otherwise stay; ready_o=0, result_o=0.
- DIV_BYZERO: next edge -> DIV_END, result_o=0, ready_o=1.
- DIV_ON, annul_i=1: next edge -> DIV_FREE, ready_o=0, result_o=0. No result is produced.
- DIV_ON, cnt<DATA_W: one iteration per edge, cnt+1.
  - R = partial remainder, Q = quotient/dividend shift register, D = divisor.
  - T = {R[W-1:0], Q[W-1]} - {1'b0, D}, computed at DATA_W+1 bits.
  - T non-negative: R<=T[W-1:0], Q<={Q[W-2:0],1}.
  - Otherwise: R<={R[W-2:0],Q[W-1]}, Q<={Q[W-2:0],0}.
- DIV_ON, cnt==DATA_W: apply sign correction -> DIV_END, ready_o=1.
  - Signed only: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend was negative.
  - Unsigned: no correction.
  - result_o={R', Q'}.
- Latency: start accepted at edge E0; ready_o=1 after edge E33 (33 cycles). Divide-by-zero: ready_o=1 after E1.
- DIV_END: hold ready_o=1 and result_o stable while start_i=1. When start_i=0 -> DIV_FREE at next edge, ready_o=0, result_o=0. annul_i is ignored in DIV_END.
- A new start in DIV_FREE is accepted on the same edge the previous result is cleared; there is no back-to-back acceptance from DIV_END.
- Operand changes after acceptance are ignored.
- Edge case 0x80000000 / 0xFFFFFFFF, signed: the magnitude 0x80000000 is treated as unsigned. Quotient=0x80000000, remainder=0. No trap.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, signed=0, start held -> ready_o rises exactly 33 cycles after acceptance; result_o=0x00000002_0000000E. Drop start -> ready_o=0 and result_o=0 next cycle.
- Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). Also 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero: opdata1=0x1234, opdata2=0 -> DIV_BYZERO then ready_o=1 after 2 edges, result_o=0.
- Annul: start 100/7, assert annul_i for 1 cycle at cycle 10 -> state DIV_FREE, ready_o never rises. A following 50/5 start yields 0x00000000_0000000A after 33 cycles.
- Boundaries: signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF. Unsigned 3/0xFFFFFFFF -> 0x00000003_00000000.
- Reset: drive rst=0 asynchronously mid-DIV_ON at cycle 20 -> ready_o=0 and result_o=0 immediately, with no clock edge. After release, a fresh 100/7 completes correctly.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU: one quotient bit per cycle, result {rem, quo} after DATA_W+1 cycles (1 for /0).
// Level start_i is held by execute; the result is held until start_i drops, and annul_i aborts an in-flight divide.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic              sgn_div_q;
  logic              sgn1_q;
  logic              sgn2_q;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    trial   = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
    quo_fix = (sgn_div_q && (sgn1_q ^ sgn2_q)) ? -quo_q : quo_q;
    rem_fix = (sgn_div_q && sgn1_q) ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sgn_div_q <= 1'b0;
      sgn1_q    <= 1'b0;
      sgn2_q    <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state     <= DIV_ON;
              cnt       <= '0;
              rem_q     <= '0;
              quo_q     <= abs1;
              dvs_q     <= abs2;
              sgn_div_q <= signed_div_i;
              sgn1_q    <= opdata1_i[DATA_W-1];
              sgn2_q    <= opdata2_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          state    <= DIV_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            cnt <= cnt + 1'b1;
            if (!trial[DATA_W]) begin
              rem_q <= trial[DATA_W-1:0];
              quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
              rem_q <= {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
              quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            state    <= DIV_END;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end
        end
        DIV_END: begin
          if (!start_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against an arithmetic reference (native / and % on 64-bit values).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Truncating division; signed remainder takes the dividend's sign; x/0 gives 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Full handshake: accept, measure latency, check hold with start high, then release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg, input string tag);
    int n;
    logic [63:0] exp;
    exp = ref_div(a, b, sg);
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = sg; start_i = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sg;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, " result"}, result_o, exp);
    @(posedge clk);
    #1;
    check({tag, " hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " clear"}, {ready_o, result_o}, 65'd0);
  endtask

  initial begin
    int n;
    logic saw;
    logic [31:0] a, b;
    logic sg;

    #3;
    check("reset state", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle after reset", {ready_o, result_o}, 65'd0);

    do_div(32'd100, 32'd7, 1'b0, "udiv 100/7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv -7/2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv 7/-2");
    do_div(32'h1234, 32'd0, 1'b0, "div by zero");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv min/-1");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "udiv max/1");
    do_div(32'd3, 32'hFFFF_FFFF, 1'b0, "udiv 3/max");

    // Annul mid-divide: no result may ever appear.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw |= ready_o;
    end
    check("annul no ready", 64'(saw), 64'd0);
    do_div(32'd50, 32'd5, 1'b0, "after annul 50/5");

    // Async reset mid-divide.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0; start_i = 1'b0;
    #1;
    check("reset mid-divide", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b1;
    do_div(32'd100, 32'd7, 1'b0, "after reset 100/7");

    // Async reset while a result is being held.
    @(negedge clk);
    opdata1_i = 32'd9; opdata2_i = 32'd2; signed_div_i = 1'b0; start_i = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held 9/2", result_o, 64'h0000_0001_0000_0004);
    #2;
    rst = 1'b0;
    #1;
    check("reset while held", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_div(a, b, sg, $sformatf("rand %0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
